// File: rtl/vai_audit_tx2.sv
`default_nettype none
// ============================================================================
// Module   : vai_audit_tx2 (with CCI-P Tx type package vai_ccip_pkg)
// Brief    : Per-sub-AFU Tx auditor: VMID tagging, window check, base relocation.
// Revision : 1.0 - initial release
// ============================================================================

package vai_ccip_pkg;

   localparam int CCIP_CLADDR_WIDTH = 42;
   localparam int CCIP_MDATA_WIDTH  = 16;
   localparam int CCIP_CLDATA_WIDTH = 512;
   localparam int CCIP_MMIODATA_WIDTH = 64;
   localparam int CCIP_TID_WIDTH    = 9;

   typedef logic [CCIP_CLADDR_WIDTH-1:0]   t_ccip_clAddr;
   typedef logic [CCIP_MDATA_WIDTH-1:0]    t_ccip_mdata;
   typedef logic [CCIP_CLDATA_WIDTH-1:0]   t_ccip_clData;
   typedef logic [CCIP_MMIODATA_WIDTH-1:0] t_ccip_mmioData;
   typedef logic [CCIP_TID_WIDTH-1:0]      t_ccip_tid;
   typedef logic [1:0]                     t_ccip_vc;
   typedef logic [1:0]                     t_ccip_clLen;
   typedef logic [3:0]                     t_ccip_req;

   // cl_len encodes the number of extra CLs beyond the first
   localparam t_ccip_clLen eCL_LEN_1 = 2'b00;
   localparam t_ccip_clLen eCL_LEN_2 = 2'b01;
   localparam t_ccip_clLen eCL_LEN_4 = 2'b11;

   localparam t_ccip_req eREQ_RDLINE_I = 4'h0;
   localparam t_ccip_req eREQ_RDLINE_S = 4'h1;
   localparam t_ccip_req eREQ_WRLINE_I = 4'h0;
   localparam t_ccip_req eREQ_WRLINE_M = 4'h1;
   localparam t_ccip_req eREQ_WRFENCE  = 4'h4;

   typedef struct packed {
      t_ccip_vc     vc_sel;
      logic [1:0]   rsvd1;
      t_ccip_clLen  cl_len;
      t_ccip_req    req_type;
      logic [5:0]   rsvd0;
      t_ccip_clAddr address;
      t_ccip_mdata  mdata;
   } t_ccip_c0_ReqMemHdr;

   typedef struct packed {
      logic [5:0]   rsvd2;
      t_ccip_vc     vc_sel;
      logic         sop;
      logic         rsvd1;
      t_ccip_clLen  cl_len;
      t_ccip_req    req_type;
      logic [5:0]   rsvd0;
      t_ccip_clAddr address;
      t_ccip_mdata  mdata;
   } t_ccip_c1_ReqMemHdr;

   typedef struct packed {
      t_ccip_tid tid;
   } t_ccip_c2_RspMmioHdr;

   typedef struct packed {
      t_ccip_c0_ReqMemHdr hdr;
      logic               valid;
   } t_if_ccip_c0_Tx;

   typedef struct packed {
      t_ccip_c1_ReqMemHdr hdr;
      t_ccip_clData       data;
      logic               valid;
   } t_if_ccip_c1_Tx;

   typedef struct packed {
      t_ccip_c2_RspMmioHdr hdr;
      logic                mmioRdValid;
      t_ccip_mmioData      data;
   } t_if_ccip_c2_Tx;

   typedef struct packed {
      t_if_ccip_c0_Tx c0;
      t_if_ccip_c1_Tx c1;
      t_if_ccip_c2_Tx c2;
   } t_if_ccip_Tx;

endpackage

module vai_audit_tx2
   import vai_ccip_pkg::*;
#(
   parameter int NUM_SUB_AFUS = 8,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                                   clk,
   input  logic                                   reset_n,
   input  t_if_ccip_Tx  [NUM_SUB_AFUS-1:0]        afu_TxPort,
   input  t_ccip_clAddr [NUM_SUB_AFUS-1:0]        vm_base,
   input  t_ccip_clAddr [NUM_SUB_AFUS-1:0]        vm_size,
   output t_if_ccip_Tx  [NUM_SUB_AFUS-1:0]        up_TxPort,
   output logic [NUM_SUB_AFUS-1:0][CNT_WIDTH-1:0] viol_cnt,
   output logic [NUM_SUB_AFUS-1:0][1:0]           viol_pulse
);

   localparam int VMID_WIDTH = (NUM_SUB_AFUS > 1) ? $clog2(NUM_SUB_AFUS) : 1;

   // Reset asserts asynchronously, releases on the 2nd clk after reset_n rises
   logic [1:0] r_rst_sync;
   logic       w_rst_n;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rst_sync <= 2'b00;
      end else begin
         r_rst_sync <= {r_rst_sync[0], 1'b1};
      end
   end

   assign w_rst_n = r_rst_sync[1];

   // One bit wider than the address so a carry out of address + cl_len is illegal
   function automatic logic f_in_window(
      input t_ccip_clAddr addr,
      input t_ccip_clLen  len,
      input t_ccip_clAddr size
   );
      logic [CCIP_CLADDR_WIDTH:0] w_last;
      w_last = {1'b0, addr} + {{(CCIP_CLADDR_WIDTH-1){1'b0}}, len};
      return (w_last < {1'b0, size});
   endfunction

   for (genvar n = 0; n < NUM_SUB_AFUS; n++) begin : g_lane

      localparam logic [VMID_WIDTH-1:0] c_LANE_ID = VMID_WIDTH'(n);

      t_if_ccip_Tx          r_t1;
      t_if_ccip_Tx          r_t2;
      logic                 r_c0_ok;
      logic                 r_c1_ok;
      logic                 w_c0_ok;
      logic                 w_c1_ok;
      t_if_ccip_Tx          w_t3;
      logic [1:0]           w_drop;
      logic [CNT_WIDTH:0]   w_cnt_sum;
      logic [CNT_WIDTH-1:0] w_cnt_next;
      t_if_ccip_Tx          r_up;
      logic [1:0]           r_pulse;
      logic [CNT_WIDTH-1:0] r_cnt;

      always_ff @(posedge clk or negedge w_rst_n) begin
         if (!w_rst_n) begin
            r_t1 <= '0;
         end else begin
            r_t1 <= afu_TxPort[n];
         end
      end

      always_comb begin
         w_c0_ok = f_in_window(r_t1.c0.hdr.address, r_t1.c0.hdr.cl_len, vm_size[n]);
         w_c1_ok = (r_t1.c1.hdr.req_type == eREQ_WRFENCE) ||
                   f_in_window(r_t1.c1.hdr.address, r_t1.c1.hdr.cl_len, vm_size[n]);
      end

      always_ff @(posedge clk or negedge w_rst_n) begin
         if (!w_rst_n) begin
            r_t2    <= '0;
            r_c0_ok <= 1'b0;
            r_c1_ok <= 1'b0;
         end else begin
            r_t2    <= r_t1;
            r_c0_ok <= w_c0_ok;
            r_c1_ok <= w_c1_ok;
         end
      end

      // Legal requests get relocated and VMID-tagged; dropped ones leave an idle slot
      always_comb begin
         w_t3   = '0;
         w_drop = 2'b00;
         w_t3.c2 = r_t2.c2;
         if (r_t2.c0.valid) begin
            if (r_c0_ok) begin
               w_t3.c0             = r_t2.c0;
               w_t3.c0.hdr.address = vm_base[n] + r_t2.c0.hdr.address;
               w_t3.c0.hdr.mdata   = {c_LANE_ID,
                                      r_t2.c0.hdr.mdata[CCIP_MDATA_WIDTH-1-VMID_WIDTH:0]};
            end else begin
               w_drop[0] = 1'b1;
            end
         end
         if (r_t2.c1.valid) begin
            if (r_c1_ok) begin
               w_t3.c1             = r_t2.c1;
               w_t3.c1.hdr.address = vm_base[n] + r_t2.c1.hdr.address;
               w_t3.c1.hdr.mdata   = {c_LANE_ID,
                                      r_t2.c1.hdr.mdata[CCIP_MDATA_WIDTH-1-VMID_WIDTH:0]};
            end else begin
               w_drop[1] = 1'b1;
            end
         end
      end

      always_comb begin
         w_cnt_sum  = {1'b0, r_cnt}
                    + {{CNT_WIDTH{1'b0}}, w_drop[0]}
                    + {{CNT_WIDTH{1'b0}}, w_drop[1]};
         w_cnt_next = w_cnt_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : w_cnt_sum[CNT_WIDTH-1:0];
      end

      always_ff @(posedge clk or negedge w_rst_n) begin
         if (!w_rst_n) begin
            r_up    <= '0;
            r_pulse <= 2'b00;
            r_cnt   <= '0;
         end else begin
            r_up    <= w_t3;
            r_pulse <= w_drop;
            r_cnt   <= w_cnt_next;
         end
      end

      assign up_TxPort[n]  = r_up;
      assign viol_pulse[n] = r_pulse;
      assign viol_cnt[n]   = r_cnt;

   end : g_lane

endmodule

`default_nettype wire
